memory_resp_unit: RTL
=====================

// Module: memory_resp_unit
// PURPOSE
// - Memory-side responder for the memory-wait pipeline stage: accepts one load/store request
//   (addr, wdata, rt, pc) from the memory stage and holds it for WAIT_CYCLES.
// - Performs the access on a word-addressed data RAM and returns rd_data/rt/pc with status_rdy.
// - The memory-wait stage stalls on !status_rdy; this block is the ready-generating end of that interface.
// PARAMETERS
// - ADDR_W       7   word-address width; RAM depth = 2**ADDR_W words of 32 bits
// - WAIT_CYCLES  2   cycles between request accept and response; legal range 0..15
// PORTS
// - clk         in   1       single clock, all state on posedge
// - rst         in   1       asynchronous, active-high reset
// - req_valid   in   1       memory stage presents a request
// - req_ready   out  1       block can accept a request this cycle
// - req_we      in   1       1 = store, 0 = load
// - req_addr    in   ADDR_W  word address
// - req_wdata   in   32      store data
// - req_rt      in   4       destination/source register tag, echoed back
// - req_pc      in   7       pc of the instruction, echoed back
// - flush       in   1       squash the in-flight request (branch/exception)
// - status_rdy  out  1       response valid (load data valid / store committed)
// - resp_ready  in   1       memory-wait stage consumes the response
// - rd_data     out  32      load data; 0 for stores
// - rd_rt       out  4       echoed req_rt
// - rd_pc       out  7       echoed req_pc
// - rd_we       out  1       echoed req_we
// BEHAVIOUR
// - FSM states: IDLE, WAIT, RESP.
// - Reset (async, any state): state=IDLE, counter=0, status_rdy=0, rd_data=0, rd_rt=0, rd_pc=0, rd_we=0.
//   RAM contents are not reset.
// - req_ready = (state==IDLE) | (state==RESP & resp_ready); it is combinational from state and resp_ready.
//   It is forced to 0 while flush=1.
// - Accept = req_valid & req_ready at edge T: latch we/addr/wdata/rt/pc.
//   - WAIT_CYCLES>0: go to WAIT with cnt=WAIT_CYCLES-1.
//   - WAIT_CYCLES==0: go straight to RESP.
// - WAIT: cnt decrements each cycle; on the edge where cnt==0, go to RESP.
//   status_rdy first rises in cycle T+1+WAIT_CYCLES.
// - RAM access happens on the edge entering RESP:
//   - store: RAM[addr] <= wdata.
//   - load: rd_data <= RAM[addr], which is the value before any store on that same edge.
// - RESP: status_rdy=1. rd_* are held stable until resp_ready=1.
//   - On handshake with no new accept: go to IDLE and clear status_rdy.
//   - On handshake with a simultaneous accept: load the new request and go to WAIT or RESP as above.
//     With WAIT_CYCLES==0 this gives back-to-back responses.
// - Back-to-back read-after-write to the same address sees the new data, because the RAM write
//   completes before the next RESP entry.
// - flush:
//   - in WAIT: go to IDLE with no RAM write and no response.
//   - in RESP: drop the response and go to IDLE; a committed store stays written.
//   - in IDLE: no effect.
//   - flush has priority over accept and over resp_ready in the same cycle.
// - Address arithmetic: req_addr indexes the RAM directly; no byte offset, no bounds error
//   (the full 2**ADDR_W range is valid).
// - Counter is 4 bits wide and saturates at 0; it never wraps.
// STRUCTURE
// - Shared package mem_resp_pkg holds:
//   - typedef enum logic[1:0] {MR_IDLE, MR_WAIT, MR_RESP} mr_state_t;
//   - localparam MR_CNT_W = 4;
//   - typedef struct packed {we, addr, wdata, rt, pc} mem_req_t.
// - One sub-module: data_ram.
//   - Parameterised by ADDR_W; 32-bit words; synchronous write and synchronous read enabled by a
//     single access strobe.
//   - The FSM, counter and request latch stay in memory_resp_unit.
// TESTING
// 1. Reset: assert rst mid-WAIT -> status_rdy=0, req_ready=1 next cycle, no RAM write at the
//    pending addr.
// 2. Store then load, WAIT_CYCLES=2:
//    - store addr=5 wdata=0xDEADBEEF accepted at T -> status_rdy at T+3, rd_we=1, rd_data=0.
//    - load addr=5 -> rd_data=0xDEADBEEF, rd_rt/rd_pc echo the load's rt=3 pc=0x12.
// 3. Backpressure: hold resp_ready=0 for 4 cycles in RESP -> status_rdy stays 1, rd_* unchanged,
//    req_ready=0. Then resp_ready=1 -> IDLE.
// 4. Back-to-back, WAIT_CYCLES=0:
//    - store addr=9 wdata=0x1 then load addr=9 on consecutive handshake cycles -> the load
//      returns 0x1 on the very next cycle.
// 5. Flush:
//    - flush in WAIT for a store to addr=7 (old 0xA) -> no response; a later load of addr=7
//      returns 0xA.
//    - flush together with resp_ready in RESP -> the response is dropped and the next request
//      is accepted only after flush deasserts.
// 6. Max latency WAIT_CYCLES=15: accept at T -> status_rdy first high at T+16, never earlier.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types for the memory responder: FSM state encoding, wait-counter
// width and the latched request record.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        MR_IDLE = 2'd0,
        MR_WAIT = 2'd1,
        MR_RESP = 2'd2
    } mr_state_t;

    localparam int MR_CNT_W = 4;

    // The address field is sized for the widest RAM we expect to hang off
    // this block; the top slices it down to its own ADDR_W.
    localparam int MR_ADDR_FIELD_W = 16;

    typedef struct packed {
        logic                       we;
        logic [MR_ADDR_FIELD_W-1:0] addr;
        logic [31:0]                wdata;
        logic [3:0]                 rt;
        logic [6:0]                 pc;
    } mem_req_t;

endpackage

// File: rtl/memory_resp_unit_data_ram.sv
// Word-addressed 32-bit data RAM. A single access strobe qualifies both the
// write and the registered read; a read on a write edge returns the old word.
module data_ram #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              access,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    // Storage array: written on a store access, never reset.
    always_ff @(posedge clk) begin
        if (access && we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register: captures the pre-write word on every access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (access) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/memory_resp_unit.sv
// Memory-side responder: accepts one load/store, holds it for WAIT_CYCLES,
// performs the RAM access on entry to RESP and presents the response until
// the memory-wait stage takes it.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   MR_IDLE | no request held, ready to accept
//   MR_WAIT | request latched, counting down the access latency
//   MR_RESP | access done, response presented on rd_* with status_rdy
import mem_resp_pkg::*;

module memory_resp_unit #(
    parameter int ADDR_W      = 7,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_rt,
    input  logic [6:0]        req_pc,
    input  logic              flush,
    output logic              status_rdy,
    input  logic              resp_ready,
    output logic [31:0]       rd_data,
    output logic [3:0]        rd_rt,
    output logic [6:0]        rd_pc,
    output logic              rd_we
);

    localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [MR_CNT_W-1:0] CNT_INIT =
        ZERO_WAIT ? '0 : MR_CNT_W'(WAIT_CYCLES - 1);

    mr_state_t             state;
    logic [MR_CNT_W-1:0]   cnt;
    mem_req_t              req_q;
    mem_req_t              req_in;
    mem_req_t              req_sel;
    logic                  accept;
    logic                  wait_done;
    logic                  enter_resp;
    logic [31:0]           ram_rdata;

    // Incoming request packed into the shared record.
    always_comb begin
        req_in       = '0;
        req_in.we    = req_we;
        req_in.addr  = MR_ADDR_FIELD_W'(req_addr);
        req_in.wdata = req_wdata;
        req_in.rt    = req_rt;
        req_in.pc    = req_pc;
    end

    // Handshake and RESP-entry decode; flush masks both.
    always_comb begin
        req_ready  = !flush &&
                     ((state == MR_IDLE) || ((state == MR_RESP) && resp_ready));
        accept     = req_valid && req_ready;
        wait_done  = (state == MR_WAIT) && (cnt == '0) && !flush;
        enter_resp = wait_done || (accept && ZERO_WAIT);
        // With zero latency the request goes to the RAM on its accept edge,
        // so it bypasses the latch.
        req_sel    = (accept && ZERO_WAIT) ? req_in : req_q;
    end

    // FSM, latency counter and request latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MR_IDLE;
            cnt   <= '0;
            req_q <= '0;
        end else if (flush) begin
            state <= MR_IDLE;
            cnt   <= '0;
        end else if (accept) begin
            req_q <= req_in;
            cnt   <= CNT_INIT;
            state <= ZERO_WAIT ? MR_RESP : MR_WAIT;
        end else begin
            case (state)
                MR_WAIT: begin
                    if (cnt == '0) begin
                        state <= MR_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                MR_RESP: begin
                    if (resp_ready) begin
                        state <= MR_IDLE;
                    end
                end
                MR_IDLE: state <= MR_IDLE;
                default: state <= MR_IDLE;
            endcase
        end
    end

    // Response sideband captured on the same edge as the RAM access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_rt <= '0;
            rd_pc <= '0;
            rd_we <= 1'b0;
        end else if (enter_resp) begin
            rd_rt <= req_sel.rt;
            rd_pc <= req_sel.pc;
            rd_we <= req_sel.we;
        end
    end

    data_ram #(
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .access (enter_resp),
        .we     (req_sel.we),
        .addr   (req_sel.addr[ADDR_W-1:0]),
        .wdata  (req_sel.wdata),
        .rdata  (ram_rdata)
    );

    // Stores report zero data; the read register still sampled the old word.
    always_comb begin
        status_rdy = (state == MR_RESP);
        rd_data    = rd_we ? 32'd0 : ram_rdata;
    end

endmodule
